// File: rtl/keccak_mode_padder_pkg.sv
// ============================================================================
// Module   : keccak_mode_padder_pkg
// Purpose  : Shared mode codes, rates, padding suffixes and FSM state type
//            for the multi-mode Keccak message padder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keccak_mode_padder_pkg;

    localparam logic [1:0] MODE_SHA3_256 = 2'b00;
    localparam logic [1:0] MODE_SHA3_512 = 2'b01;
    localparam logic [1:0] MODE_SHAKE128 = 2'b10;
    localparam logic [1:0] MODE_SHAKE256 = 2'b11;

    localparam int unsigned RATE_SHA3_256 = 1088;
    localparam int unsigned RATE_SHA3_512 = 576;
    localparam int unsigned RATE_SHAKE128 = 1344;
    localparam int unsigned RATE_SHAKE256 = 1088;

    localparam logic [7:0] SUFX_SHA3  = 8'h06;
    localparam logic [7:0] SUFX_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DONE  = 2'd3
    } pad_state_t;

    // Rate in bits of the sponge for a given mode code
    function automatic int unsigned rate_bits(input logic [1:0] mode);
        case (mode)
            MODE_SHA3_256: rate_bits = RATE_SHA3_256;
            MODE_SHA3_512: rate_bits = RATE_SHA3_512;
            MODE_SHAKE128: rate_bits = RATE_SHAKE128;
            default:       rate_bits = RATE_SHAKE256;
        endcase
    endfunction

    // Domain-separation suffix: SHAKE modes have the MSB of the mode code set
    function automatic logic [7:0] suffix_of(input logic [1:0] mode);
        suffix_of = mode[1] ? SUFX_SHAKE : SUFX_SHA3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_mode_padder_if.sv
// ============================================================================
// Module   : keccak_mode_padder_if
// Purpose  : Message-in / block-out bus of the Keccak padder.
//            KECCAK_PAD_BLKCNT_EN adds the blk_cnt[15:0] block counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keccak_mode_padder_if #(
    parameter int IN_W     = 32,
    parameter int MAX_RATE = 1344,
    parameter int BN_W     = $clog2(IN_W / 8)
);
    logic                clear;
    logic [1:0]          mode;
    logic [IN_W-1:0]     in;
    logic                in_ready;
    logic                is_last;
    logic [BN_W-1:0]     byte_num;
    logic                buffer_full;
    logic [MAX_RATE-1:0] out;
    logic                out_ready;
    logic                f_ack;
    logic                last_blk;
`ifdef KECCAK_PAD_BLKCNT_EN
    logic [15:0]         blk_cnt;
`endif

    modport master (
        output clear, mode, in, in_ready, is_last, byte_num, f_ack,
`ifdef KECCAK_PAD_BLKCNT_EN
        input  blk_cnt,
`endif
        input  buffer_full, out, out_ready, last_blk
    );

    modport slave (
        input  clear, mode, in, in_ready, is_last, byte_num, f_ack,
`ifdef KECCAK_PAD_BLKCNT_EN
        output blk_cnt,
`endif
        output buffer_full, out, out_ready, last_blk
    );
endinterface

`default_nettype wire

// File: rtl/keccak_mode_padder_pad_word.sv
// ============================================================================
// Module   : keccak_mode_padder_pad_word
// Purpose  : Combinational padding of the final message word: keeps the
//            first byte_num bytes, inserts the suffix, zeroes the rest and
//            optionally ORs the 0x80 end marker into the LSB byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_mode_padder_pad_word
    import keccak_mode_padder_pkg::*;
#(
    parameter int IN_W = 32,
    parameter int BN_W = $clog2(IN_W / 8)
) (
    input  wire logic [IN_W-1:0] i_word,
    input  wire logic [BN_W-1:0] i_byte_num,
    input  wire logic [7:0]      i_suffix,
    input  wire logic            i_put_end,
    output logic      [IN_W-1:0] o_word
);
    localparam int NB = IN_W / 8;

    // Byte 0 sits in the MSBs; select data, suffix or zero per byte lane
    always_comb begin
        o_word = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < int'(i_byte_num)) begin
                o_word[IN_W-1-8*b -: 8] = i_word[IN_W-1-8*b -: 8];
            end else if (b == int'(i_byte_num)) begin
                o_word[IN_W-1-8*b -: 8] = i_suffix;
            end
        end
        if (i_put_end) begin
            o_word[7:0] = o_word[7:0] | PAD_END;
        end
    end

endmodule

`default_nettype wire

// File: rtl/keccak_mode_padder.sv
// ============================================================================
// Module   : keccak_mode_padder
// Purpose  : Multi-mode Keccak padder (SHA3-256/512, SHAKE128/256). Packs
//            message words into a rate-sized block, appends suffix and end
//            marker, and hands blocks over with a valid/ack handshake.
//            Optional: KECCAK_PAD_BLKCNT_EN adds a saturating block counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_mode_padder
    import keccak_mode_padder_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int MAX_RATE = 1344
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    keccak_mode_padder_if.slave bus
);
    localparam int NW_MAX = MAX_RATE / IN_W;
    localparam int WC_W   = $clog2(NW_MAX + 1);
    localparam int BASE_W = $clog2(MAX_RATE);
    localparam int BN_W   = $clog2(IN_W / 8);

    pad_state_t          r_state;
    logic [WC_W-1:0]     r_wcnt;
    logic [MAX_RATE-1:0] r_blk;
    logic                r_out_ready;
    logic                r_last;
    logic                r_open;
    logic [1:0]          r_mode;
`ifdef KECCAK_PAD_BLKCNT_EN
    logic [15:0]         r_blk_cnt;
`endif

    logic [1:0]          w_mode;
    logic [WC_W-1:0]     w_nw;
    logic                w_at_end;
    logic [BASE_W-1:0]   w_base;
    logic [7:0]          w_suffix;
    logic [IN_W-1:0]     w_pad_word;
    logic [IN_W-1:0]     w_acc_word;
    logic [IN_W-1:0]     w_fill_word;

    // Mode comes straight from the bus only for the opening word of a message
    assign w_mode      = r_open ? r_mode : bus.mode;
    assign w_nw        = WC_W'(rate_bits(w_mode) / IN_W);
    assign w_at_end    = (r_wcnt == (w_nw - WC_W'(1)));
    assign w_base      = BASE_W'(MAX_RATE - 1 - int'(r_wcnt) * IN_W);
    assign w_suffix    = suffix_of(w_mode);
    assign w_acc_word  = bus.is_last ? w_pad_word : bus.in;
    assign w_fill_word = w_at_end ? {{(IN_W-8){1'b0}}, PAD_END} : '0;

    keccak_mode_padder_pad_word #(
        .IN_W (IN_W),
        .BN_W (BN_W)
    ) u_pad_word (
        .i_word     (bus.in),
        .i_byte_num (bus.byte_num),
        .i_suffix   (w_suffix),
        .i_put_end  (w_at_end),
        .o_word     (w_pad_word)
    );

    // Padder FSM: word packing, zero fill, block handshake and message end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ACCUM;
            r_wcnt      <= '0;
            r_blk       <= '0;
            r_out_ready <= 1'b0;
            r_last      <= 1'b0;
            r_open      <= 1'b0;
            r_mode      <= MODE_SHA3_256;
`ifdef KECCAK_PAD_BLKCNT_EN
            r_blk_cnt   <= '0;
`endif
        end else if (bus.clear) begin
            r_state     <= ST_ACCUM;
            r_wcnt      <= '0;
            r_blk       <= '0;
            r_out_ready <= 1'b0;
            r_last      <= 1'b0;
            r_open      <= 1'b0;
`ifdef KECCAK_PAD_BLKCNT_EN
            r_blk_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (bus.in_ready) begin
                        if (!r_open) begin
                            r_mode <= bus.mode;
                            r_open <= 1'b1;
                        end
                        r_blk[w_base -: IN_W] <= w_acc_word;
                        if (bus.is_last) begin
                            r_last <= 1'b1;
                        end
                        if (w_at_end) begin
                            r_state     <= ST_FULL;
                            r_out_ready <= 1'b1;
                            r_wcnt      <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + WC_W'(1);
                            if (bus.is_last) begin
                                r_state <= ST_FILL;
                            end
                        end
                    end
                end
                ST_FILL: begin
                    r_blk[w_base -: IN_W] <= w_fill_word;
                    if (w_at_end) begin
                        r_state     <= ST_FULL;
                        r_out_ready <= 1'b1;
                        r_wcnt      <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + WC_W'(1);
                    end
                end
                ST_FULL: begin
                    if (bus.f_ack) begin
                        r_out_ready <= 1'b0;
                        r_blk       <= '0;
                        r_state     <= r_last ? ST_DONE : ST_ACCUM;
`ifdef KECCAK_PAD_BLKCNT_EN
                        if (r_blk_cnt != 16'hFFFF) begin
                            r_blk_cnt <= r_blk_cnt + 16'd1;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign bus.buffer_full = (r_state != ST_ACCUM);
    assign bus.out         = r_blk;
    assign bus.out_ready   = r_out_ready;
    assign bus.last_blk    = r_last;
`ifdef KECCAK_PAD_BLKCNT_EN
    assign bus.blk_cnt     = r_blk_cnt;
`endif

endmodule

`default_nettype wire
